flash_access_arbiter: RTL

FLASH_ACCESS_ARBITER -- requirements
Module: flash_access_arbiter

---
 rtl/flash_arb_pkg.sv | 19 +
 rtl/flash_arb_rr_pick.sv | 29 ++
 rtl/flash_access_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/flash_arb_pkg.sv
// Shared types and constants for the on-chip flash read arbiter.
// Optional read timeout is enabled with macro FLASH_ARB_TIMEOUT_EN.
package flash_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_DATA = 2'd2
    } state_e;

    localparam int unsigned DEF_ADDR_WIDTH     = 13;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 255;
    localparam logic [31:0] TIMEOUT_DATA       = 32'hFFFF_FFFF;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/flash_arb_rr_pick.sv
// Combinational round-robin picker: searches upward from last_grant+1 modulo NUM_REQ.
module flash_arb_rr_pick
    import flash_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   winner_idx
);

    logic found;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            if (!found && req[(int'(last_grant) + k) % int'(NUM_REQ)]) begin
                found = 1'b1;
                winner[(int'(last_grant) + k) % int'(NUM_REQ)] = 1'b1;
                winner_idx = IDX_W'((int'(last_grant) + k) % int'(NUM_REQ));
            end
        end
    end

endmodule

// File: rtl/flash_access_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM flash read port among NUM_REQ requesters.
// Define FLASH_ARB_TIMEOUT_EN to add a read-data timeout that completes with rsp_err=1.
module flash_access_arbiter
    import flash_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            grant,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [31:0]                   rsp_data,
    output logic                          rsp_err,
    output logic                          busy,
    output logic [ADDR_WIDTH-1:0]         avmm_data_addr,
    output logic                          avmm_data_read,
    output logic [1:0]                    avmm_data_burstcount,
    input  logic [31:0]                   avmm_data_readdata,
    input  logic                          avmm_data_readdatavalid,
    input  logic                          avmm_data_waitrequest
);

    localparam int unsigned IDX_W = idx_width(NUM_REQ);

    state_e                  state_q, state_d;
    logic [NUM_REQ-1:0]      grant_q, grant_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [IDX_W-1:0]        last_q, last_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic [31:0]             rsp_data_q, rsp_data_d;
    logic [NUM_REQ-1:0]      win_oh;
    logic [IDX_W-1:0]        win_idx;

`ifdef FLASH_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rsp_err_q, rsp_err_d;
`endif

    flash_arb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req        (req_valid),
        .last_grant (last_q),
        .winner     (win_oh),
        .winner_idx (win_idx)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        idx_d       = idx_q;
        last_d      = last_q;
        addr_d      = addr_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
`ifdef FLASH_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        rsp_err_d   = rsp_err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (|req_valid) begin
                    grant_d = win_oh;
                    idx_d   = win_idx;
                    addr_d  = req_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!avmm_data_waitrequest) begin
                    state_d = S_WAIT_DATA;
`ifdef FLASH_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_WAIT_DATA: begin
                // Valid data takes priority over a coincident timeout.
                if (avmm_data_readdatavalid) begin
                    rsp_data_d  = avmm_data_readdata;
                    rsp_valid_d = grant_q;
                    grant_d     = '0;
                    last_d      = idx_q;
                    state_d     = S_IDLE;
`ifdef FLASH_ARB_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rsp_data_d  = TIMEOUT_DATA;
                    rsp_valid_d = grant_q;
                    rsp_err_d   = 1'b1;
                    grant_d     = '0;
                    last_d      = idx_q;
                    state_d     = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            idx_q       <= '0;
            last_q      <= IDX_W'(NUM_REQ - 1);
            addr_q      <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
`ifdef FLASH_ARB_TIMEOUT_EN
            cnt_q       <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            addr_q      <= addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
`ifdef FLASH_ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign grant                = grant_q;
    assign rsp_valid            = rsp_valid_q;
    assign rsp_data             = rsp_data_q;
    assign busy                 = (state_q != S_IDLE);
    assign avmm_data_read       = (state_q == S_ISSUE);
    assign avmm_data_addr       = addr_q;
    assign avmm_data_burstcount = 2'h1;
`ifdef FLASH_ARB_TIMEOUT_EN
    assign rsp_err              = rsp_err_q;
`else
    assign rsp_err              = 1'b0;
`endif

endmodule
